// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: register-mapped sequencer for the LED register (direct, blink, rotate-left/right).
// Defining LED_SEQ_IRQ_EN adds the step-wrap interrupt (irq port, STATUS[29], CTRL bit3 IE).
module led_seq_ctrl #(
    parameter int unsigned DEFAULT_PERIOD = 25000000,
    parameter int unsigned STEP_W         = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [3:0]  led_byteen,
    output logic [31:0] led_din
`ifdef LED_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic [1:0] M_DIRECT = 2'd0;
    localparam logic [1:0] M_BLINK  = 2'd1;
    localparam logic [1:0] M_ROTL   = 2'd2;
    localparam logic [1:0] M_ROTR   = 2'd3;

`ifdef LED_SEQ_IRQ_EN
    localparam logic [3:0] CTRL_MASK = 4'hF;
`else
    localparam logic [3:0] CTRL_MASK = 4'h7;
`endif

    state_t             state;
    logic [3:0]         ctrl;
    logic [31:0]        period;
    logic [31:0]        pattern;
    logic [31:0]        cnt;
    logic [31:0]        cur;
    logic [STEP_W-1:0]  step;
    logic               phase;
    logic               irq_pend;

    logic        wr_ctrl, wr_period, wr_pattern, wr_status;
    logic [3:0]  ctrl_nxt;
    logic        en_nxt, mode_change, run_stop, boundary, step_tick;
    logic [31:0] period_m1, cur_rotl, cur_rotr;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] r;
        r = old_val;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    assign wr_ctrl    = we && (addr == 2'd0);
    assign wr_period  = we && (addr == 2'd1);
    assign wr_pattern = we && (addr == 2'd2);
    assign wr_status  = we && (addr == 2'd3);

    // FSM decisions look at the CTRL value being written this cycle, so a disabling write stops pulses at once.
    assign ctrl_nxt    = (wr_ctrl && byteen[0]) ? (wdata[3:0] & CTRL_MASK) : ctrl;
    assign en_nxt      = ctrl_nxt[0];
    assign mode_change = wr_ctrl && (ctrl_nxt[2:1] != ctrl[2:1]);
    assign run_stop    = !en_nxt || (ctrl_nxt[2:1] == M_DIRECT);

    assign period_m1 = (period == 32'd0) ? 32'd0 : period - 32'd1;
    assign boundary  = (cnt >= period_m1);
    assign step_tick = (state == RUN) && !run_stop && !wr_pattern && !mode_change
                       && !wr_period && boundary;

    assign cur_rotl = {cur[30:0], cur[31]};
    assign cur_rotr = {cur[0], cur[31:1]};

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ctrl       <= 4'h0;
            period     <= DEFAULT_PERIOD;
            pattern    <= 32'd0;
            cnt        <= 32'd0;
            cur        <= 32'd0;
            step       <= '0;
            phase      <= 1'b0;
            irq_pend   <= 1'b0;
            led_byteen <= 4'h0;
            led_din    <= 32'd0;
        end else begin
            led_byteen <= 4'h0;
            if (wr_ctrl)    ctrl    <= ctrl_nxt;
            if (wr_period)  period  <= merge_bytes(period, wdata, byteen);
            if (wr_pattern) pattern <= merge_bytes(pattern, wdata, byteen);

            if (wr_pattern && (ctrl[2:1] == M_DIRECT)) begin
                led_byteen <= byteen;
                led_din    <= wdata;
            end

            case (state)
                IDLE: begin
                    if (en_nxt && (ctrl_nxt[2:1] != M_DIRECT)) state <= LOAD;
                end
                LOAD: begin
                    cur        <= pattern;
                    cnt        <= 32'd0;
                    phase      <= 1'b0;
                    led_byteen <= 4'hF;
                    led_din    <= pattern;
                    state      <= RUN;
                end
                RUN: begin
                    if (run_stop) begin
                        state <= IDLE;
                    end else if (wr_pattern || mode_change) begin
                        state <= LOAD;
                    end else if (wr_period) begin
                        cnt <= 32'd0;
                    end else if (boundary) begin
                        cnt        <= 32'd0;
                        led_byteen <= 4'hF;
                        case (ctrl[2:1])
                            M_BLINK: begin
                                phase   <= ~phase;
                                led_din <= phase ? pattern : 32'd0;
                            end
                            M_ROTL: begin
                                cur     <= cur_rotl;
                                led_din <= cur_rotl;
                            end
                            M_ROTR: begin
                                cur     <= cur_rotr;
                                led_din <= cur_rotr;
                            end
                            default: ;
                        endcase
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A STATUS write beats a simultaneous step increment.
            if (wr_status) begin
                step     <= '0;
                irq_pend <= 1'b0;
            end else if (step_tick) begin
                step <= step + 1'b1;
`ifdef LED_SEQ_IRQ_EN
                if (&step) irq_pend <= 1'b1;
`endif
            end
        end
    end

    // NOTE: rdata gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        rdata = 32'd0;
        case (addr)
            2'd0: rdata[3:0] = ctrl;
            2'd1: rdata = period;
            2'd2: rdata = pattern;
            2'd3: begin
                rdata[31:30]       = state;
                rdata[29]          = irq_pend;
                rdata[28]          = phase;
                rdata[STEP_W-1:0]  = step;
            end
            default: rdata = 32'd0;
        endcase
    end

`ifdef LED_SEQ_IRQ_EN
    assign irq = irq_pend & ctrl[3];
`endif

endmodule

// File: doc/led_seq_ctrl.md
Name: led_seq_ctrl

Overview:
Memory-mapped controller that sequences the board LED register. The CPU programs mode, period and pattern through a small word-addressed register file. The block then drives the LED register's byte-enable write port, either passing CPU writes straight through or generating timed blink and rotate updates autonomously. It sits between the system bridge and the LED register, and owns every write into that register.

Parameters:
- DEFAULT_PERIOD, 25000000, reset value of PERIOD in clk cycles per step.
- STEP_W, 8, width of the step counter reported in STATUS.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- we  input  1  CPU write strobe for this device
- addr  input  2  word select (byte address bits [3:2]): 0 CTRL, 1 PERIOD, 2 PATTERN, 3 STATUS
- byteen  input  4  CPU byte enables for the write
- wdata  input  32  CPU write data
- rdata  output  32  read data of the addressed register, combinational
- led_byteen  output  4  byte enables to the LED register, registered, one-cycle pulse
- led_din  output  32  data to the LED register, registered
- irq  output  1  step-wrap interrupt; present only with LED_SEQ_IRQ_EN

Behaviour:
- Reset values: CTRL=0, PERIOD=DEFAULT_PERIOD, PATTERN=0, cnt=0, step=0, phase=0, cur=0, state=IDLE, led_byteen=0, led_din=0, irq=0.
- CTRL layout: bit0 EN; bits[2:1] MODE (0 DIRECT, 1 BLINK, 2 ROTL, 3 ROTR); other bits read 0.
- CPU writes honour byteen per byte on CTRL, PERIOD and PATTERN.
- Any write to STATUS clears step and the irq pending bit; its data is ignored.
- rdata for STATUS: [31:30]=state (IDLE 0, LOAD 1, RUN 2), [29]=irq pending, [28]=phase, [STEP_W-1:0]=step, all other bits 0.
- led_byteen defaults to 0 every cycle. A write to the LED register is a one-cycle pulse, issued the cycle after the triggering event.
- DIRECT mode (MODE=0, any EN): a PATTERN write produces, next cycle, led_byteen=byteen and led_din=wdata. The FSM stays in IDLE.
- IDLE: leave when EN=1 and MODE!=0, go to LOAD.
- LOAD (one cycle): cur<=PATTERN, cnt<=0, phase<=0; emit led_byteen=4'hF, led_din=PATTERN; go to RUN.
- RUN: cnt increments each cycle. On step boundary (cnt==PERIOD-1, with PERIOD=0 treated as 1):
  - cnt<=0, step<=step+1 (wraps to 0 after 2^STEP_W-1), emit led_byteen=4'hF.
  - BLINK: phase toggles; led_din = new phase ? 0 : PATTERN.
  - ROTL: cur<={cur[30:0],cur[31]}; ROTR: cur<={cur[0],cur[31:1]}; led_din = new cur.
- In RUN:
  - EN cleared or MODE set to 0: go to IDLE next cycle, no further pulses; the LED keeps its last value.
  - Write to PATTERN, or a CTRL write changing MODE among 1..3: go to LOAD (restart from PATTERN).
  - Write to PERIOD: cnt<=0; the new period applies immediately.
- Simultaneous step boundary and restarting write: the write wins, no step pulse that cycle.
- Reset mid-RUN: all state returns to reset values the next edge; led_byteen=0.

Optional Feature:
- Macro LED_SEQ_IRQ_EN.
- Defined: irq output exists. The irq pending bit is set when step wraps from all-ones to 0, and irq equals pending & CTRL bit3 (IE, read/write).
- Not defined: no irq port, STATUS[29] reads 0, CTRL bit3 reads 0 and ignores writes.

Test Plan:
- Reset, then read all four registers -> CTRL=0, PERIOD=DEFAULT_PERIOD, PATTERN=0, STATUS=0; led_byteen=0.
- DIRECT: write PATTERN=0x12345678 with byteen=4'b0011 -> next cycle led_byteen=4'b0011, led_din=0x12345678; STATUS[31:30]=0.
- PERIOD=3, PATTERN=0x80000001, CTRL=0x5 (EN, ROTL) -> LOAD pulse with 0x80000001, then pulses every 3 cycles with 0x00000003, 0x00000006; step increments 1, 2.
- BLINK with PERIOD=0, PATTERN=0xFF -> pulse each cycle alternating led_din 0x0, 0xFF after the LOAD pulse of 0xFF.
- ROTR running, write PATTERN=0xF0 exactly on a step boundary -> no step pulse, LOAD pulse 0xF0; clear EN -> no pulses after the next cycle.
- With LED_SEQ_IRQ_EN and STEP_W=8: PERIOD=1, IE=1, run 256 steps -> irq=1; write STATUS -> irq=0, step=0.
